// File: rtl/score_bcd_scan.sv
// Score display driver: converts a 16-bit score to packed BCD with a serial
// double-dabble FSM and multiplexes the five digits onto one 7-segment output.
module score_bcd_scan #(
    parameter logic [15:0] SCAN_DIV   = 16'd50000,
    parameter int unsigned BLANK_LEAD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic [4:0]  digit_sel,
    output logic [6:0]  seg
);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] last_q, last_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] work_q, work_d;
    logic [3:0]  iter_q, iter_d;
    logic [19:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic [15:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] adj;
    logic [19:0] upper;
    logic [3:0]  nib;
    logic        blank;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= '0;
            shift_q <= '0;
            work_q  <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Converter: one double-dabble step per edge, 16 steps per score.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        work_d  = work_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        adj     = work_q;
        for (int i = 0; i < 5; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (score != last_q) begin
                    shift_d = score;
                    last_d  = score;
                    work_d  = '0;
                    iter_d  = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                work_d  = {adj[18:0], shift_q[15]};
                shift_d = {shift_q[14:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) state_d = DONE;
            end
            DONE: begin
                bcd_d   = work_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan runs off the registered bcd only, never the work register.
    always_comb begin
        presc_d = presc_q + 16'd1;
        idx_d   = idx_q;
        if (presc_q == SCAN_DIV - 16'd1) begin
            presc_d = '0;
            idx_d   = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        upper = bcd_q >> {idx_q, 2'b00};
        nib   = upper[3:0];
        blank = (BLANK_LEAD != 0) && (idx_q != 3'd0) && (upper == 20'd0);
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        if (blank) seg = 7'h00;
        digit_sel = 5'b00001 << idx_q;
    end

    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_score_bcd_scan.sv
// Self-checking bench for score_bcd_scan: arithmetic BCD/segment reference,
// latency and pulse-width checks, scan sequencing, mid-conversion reset.
module tb_score_bcd_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] score = '0;
    logic [19:0] bcd;
    logic        bcd_valid;
    logic [4:0]  digit_sel;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;
    int cur_val = 0;
    int last_m = 0;
    int ecnt = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    score_bcd_scan #(.SCAN_DIV(16'd4), .BLANK_LEAD(1)) dut (
        .clk(clk), .reset(reset), .score(score), .bcd(bcd),
        .bcd_valid(bcd_valid), .digit_sel(digit_sel), .seg(seg)
    );

    always #5 clk = ~clk;

    // Edges since reset release: prescaler = ecnt % 4, digit = (ecnt / 4) % 5.
    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int d;
        r = '0;
        d = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (idx > 0 && v / p == 0) return 7'h00;
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        score = '0;
        #3;
        checks++;
        if (bcd !== 20'h0 || bcd_valid !== 1'b0 || digit_sel !== 5'b00001 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL reset_state: bcd=%h valid=%b sel=%b seg=%h required 00000 0 00001 3f",
                     bcd, bcd_valid, digit_sel, seg);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cur_val = 0;
        last_m = 0;
    endtask

    task automatic test_idle_zero();
        int pulses;
        int bad_scan;
        pulses = 0;
        bad_scan = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (bcd_valid === 1'b1) pulses++;
            if (digit_sel !== (5'b00001 << ((ecnt / 4) % 5)) ||
                seg !== exp_seg(0, (ecnt / 4) % 5)) bad_scan++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_zero_pulses: got %0d pulses required 0", pulses);
        end
        checks++;
        if (bad_scan != 0) begin
            errors++;
            $display("FAIL idle_zero_scan: %0d bad cycles required 0", bad_scan);
        end
        while (((ecnt / 4) % 5) != 0) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bcd !== 20'h0 || seg !== 7'h3F || digit_sel !== 5'b00001) begin
            errors++;
            $display("FAIL idle_zero_digit0: bcd=%h seg=%h sel=%b required 00000 3f 00001", bcd, seg, digit_sel);
        end
    endtask

    // Drives v after an edge; next edge N latches it; bcd/valid update at N+17.
    task automatic test_convert(input int v);
        logic [19:0] old_b;
        logic [19:0] exp_b;
        int early;
        old_b = to_bcd(cur_val);
        exp_b = to_bcd(v);
        early = 0;
        score = 16'(v);
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            if (bcd_valid !== 1'b0 || bcd !== old_b) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL convert_early(%0d): %0d cycles changed before N+17 required 0", v, early);
        end
        @(posedge clk); #1;
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== exp_b) begin
            errors++;
            $display("FAIL convert_result(%0d): bcd=%h valid=%b required %h 1", v, bcd, bcd_valid, exp_b);
        end
        @(posedge clk); #1;
        checks++;
        if (bcd_valid !== 1'b0 || bcd !== exp_b) begin
            errors++;
            $display("FAIL convert_pulse_end(%0d): bcd=%h valid=%b required %h 0", v, bcd, bcd_valid, exp_b);
        end
        cur_val = v;
        last_m = v;
    endtask

    task automatic test_scan(input int n);
        int idx;
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            idx = (ecnt / 4) % 5;
            if (digit_sel !== (5'b00001 << idx) || seg !== exp_seg(cur_val, idx)) begin
                bad++;
                if (bad == 1)
                    $display("FAIL scan(%0d) digit %0d: sel=%b seg=%h required %b %h", cur_val, idx,
                             digit_sel, seg, 5'b00001 << idx, exp_seg(cur_val, idx));
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        score = 16'd256;
        repeat (5) @(posedge clk);
        #1;
        score = 16'd512;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bcd_valid !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== 20'h00256) begin
            errors++;
            $display("FAIL b2b_first: bcd=%h valid=%b required 00256 1", bcd, bcd_valid);
        end
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            if (bcd_valid !== 1'b0 || bcd !== 20'h00256) bad++;
        end
        @(posedge clk); #1;
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== 20'h00512) begin
            errors++;
            $display("FAIL b2b_second: bcd=%h valid=%b required 00512 1", bcd, bcd_valid);
        end
        @(posedge clk); #1;
        if (bcd_valid !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_quiet: %0d unexpected cycles required 0", bad);
        end
        cur_val = 512;
        last_m = 512;
    endtask

    task automatic test_reset_mid();
        score = 16'd100;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bcd !== 20'h0 || bcd_valid !== 1'b0 || digit_sel !== 5'b00001 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL reset_mid_async: bcd=%h valid=%b sel=%b seg=%h required 00000 0 00001 3f",
                     bcd, bcd_valid, digit_sel, seg);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cur_val = 0;
        last_m = 0;
        test_convert(100);
    endtask

    task automatic test_random();
        int v;
        for (int r = 0; r < 6; r++) begin
            v = int'($urandom_range(0, 65535));
            if (v == last_m) v = v ^ 1;
            test_convert(v);
            test_scan(22);
        end
    endtask

    initial begin
        test_reset();
        test_idle_zero();
        test_convert(12345);
        test_scan(25);
        test_convert(65535);
        test_scan(25);
        test_convert(0);
        test_scan(25);
        test_convert(32);
        test_scan(40);
        test_back_to_back();
        test_scan(20);
        test_reset_mid();
        test_scan(20);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
